wall_collision_scheduler: RTL and testbench

Frame-rate scheduler that time-multiplexes one box-overlap comparator across a table of NUM_WALLS wall boxes. It tests the player box against each wall and reports a per-wall hit mask plus an aggregate collide flag. It sits between the frame-tick generator and the player-motion logic, which uses collide and hit_index to block or land the player. Wall packing matches the existing 44-bit format: [43:33] bottomy, [32:22] topy, [21:11] rightx, [10:0] leftx.

---
 rtl/wall_collision_scheduler_pkg.sv | 19 +
 rtl/wall_collision_scheduler_box_overlap_check.sv | 36 +++
 rtl/wall_collision_scheduler.sv | 137 +++++++++++++
 tb/tb_wall_collision_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wall_collision_scheduler_pkg.sv
// rtl/wall_collision_scheduler_pkg.sv - shared wall packing constants and scheduler state encoding
package wall_collision_scheduler_pkg;

  localparam int COORD_W = 11;
  localparam int WALL_W  = 4 * COORD_W;

  localparam int WALL_LEFTX_LSB   = 0;
  localparam int WALL_RIGHTX_LSB  = COORD_W;
  localparam int WALL_TOPY_LSB    = 2 * COORD_W;
  localparam int WALL_BOTTOMY_LSB = 3 * COORD_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNAP = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/wall_collision_scheduler_box_overlap_check.sv
// rtl/wall_collision_scheduler_box_overlap_check.sv - combinational player-vs-wall box overlap test
module box_overlap_check
  import wall_collision_scheduler_pkg::*;
#(
  parameter int CW = COORD_W
) (
  input  logic            en,
  input  logic [CW-1:0]   topy,
  input  logic [CW-1:0]   bottomy,
  input  logic [CW-1:0]   leftx,
  input  logic [CW-1:0]   rightx,
  input  logic [4*CW-1:0] wall,
  output logic            hit
);

  logic [CW-1:0] w_leftx;
  logic [CW-1:0] w_rightx;
  logic [CW-1:0] w_topy;
  logic [CW-1:0] w_bottomy;
  logic [CW:0]   bottom_ext;

  assign w_leftx   = wall[0*CW +: CW];
  assign w_rightx  = wall[1*CW +: CW];
  assign w_topy    = wall[2*CW +: CW];
  assign w_bottomy = wall[3*CW +: CW];

  // One extra bit so a player resting on the bottom row still touches a wall below it.
  assign bottom_ext = {1'b0, bottomy} + {{CW{1'b0}}, 1'b1};

  assign hit = en
            && (leftx <= w_rightx)
            && (rightx >= w_leftx)
            && (topy <= w_bottomy)
            && (bottom_ext >= {1'b0, w_topy});

endmodule

// File: rtl/wall_collision_scheduler.sv
// rtl/wall_collision_scheduler.sv - one-comparator wall scan per frame tick; COLLIDE_EARLY_EXIT_EN stops at first hit
module wall_collision_scheduler
  import wall_collision_scheduler_pkg::*;
#(
  parameter int NUM_WALLS = 4,
  parameter int IDX_W     = 4,
  parameter int COORD_W   = wall_collision_scheduler_pkg::COORD_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [COORD_W-1:0]             topy,
  input  logic [COORD_W-1:0]             bottomy,
  input  logic [COORD_W-1:0]             leftx,
  input  logic [COORD_W-1:0]             rightx,
  input  logic [NUM_WALLS*4*COORD_W-1:0] wall_list,
  input  logic [NUM_WALLS-1:0]           wall_en,
  output logic                           busy,
  output logic                           done,
  output logic                           collide,
  output logic [NUM_WALLS-1:0]           hit_mask,
  output logic [IDX_W-1:0]               hit_index
);

  localparam int EW = 4 * COORD_W;

  state_t               state;
  logic [IDX_W-1:0]     cnt;
  logic [COORD_W-1:0]   sh_topy;
  logic [COORD_W-1:0]   sh_bottomy;
  logic [COORD_W-1:0]   sh_leftx;
  logic [COORD_W-1:0]   sh_rightx;
  logic [EW-1:0]        sh_wall [NUM_WALLS];
  logic [NUM_WALLS-1:0] sh_en;

  logic [EW-1:0]        cur_wall;
  logic                 cur_en;
  logic [NUM_WALLS-1:0] cur_onehot;
  logic                 cur_hit;
  logic                 last_entry;

  always_comb begin
    cur_wall   = '0;
    cur_en     = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < NUM_WALLS; i++) begin
      if (cnt == IDX_W'(i)) begin
        cur_wall      = sh_wall[i];
        cur_en        = sh_en[i];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  assign last_entry = (cnt == IDX_W'(NUM_WALLS - 1));

  box_overlap_check #(
    .CW(COORD_W)
  ) u_overlap (
    .en     (cur_en),
    .topy   (sh_topy),
    .bottomy(sh_bottomy),
    .leftx  (sh_leftx),
    .rightx (sh_rightx),
    .wall   (cur_wall),
    .hit    (cur_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      collide   <= 1'b0;
      hit_mask  <= '0;
      hit_index <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= ST_SNAP;
            busy  <= 1'b1;
          end
        end
        ST_SNAP: begin
          sh_topy    <= topy;
          sh_bottomy <= bottomy;
          sh_leftx   <= leftx;
          sh_rightx  <= rightx;
          sh_en      <= wall_en;
          for (int i = 0; i < NUM_WALLS; i++) begin
            sh_wall[i] <= wall_list[i*EW +: EW];
          end
          hit_mask  <= '0;
          collide   <= 1'b0;
          hit_index <= '0;
          cnt       <= '0;
          busy      <= 1'b1;
          state     <= ST_SCAN;
        end
        ST_SCAN: begin
          if (cur_hit) begin
            hit_mask <= hit_mask | cur_onehot;
            collide  <= 1'b1;
            // collide is still clear only until the first hit, which fixes the lowest index.
            if (!collide) begin
              hit_index <= cnt;
            end
          end
`ifdef COLLIDE_EARLY_EXIT_EN
          if (cur_hit || last_entry) begin
`else
          if (last_entry) begin
`endif
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wall_collision_scheduler.sv
// tb/tb_wall_collision_scheduler.sv - directed self-checking bench for wall_collision_scheduler
module tb_wall_collision_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [10:0]  topy, bottomy, leftx, rightx;
  logic [175:0] wall_list;
  logic [3:0]   wall_en;
  logic         busy, done, collide;
  logic [3:0]   hit_mask;
  logic [3:0]   hit_index;

  int checks = 0;
  int errors = 0;

`ifdef COLLIDE_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic [43:0] far_wall;
  logic [43:0] w0;

  always #5 clk = ~clk;

  wall_collision_scheduler dut (
    .clk(clk), .rst(rst), .start(start),
    .topy(topy), .bottomy(bottomy), .leftx(leftx), .rightx(rightx),
    .wall_list(wall_list), .wall_en(wall_en),
    .busy(busy), .done(done), .collide(collide),
    .hit_mask(hit_mask), .hit_index(hit_index)
  );

  function automatic logic [43:0] mkwall(input int bot, input int top, input int rx, input int lx);
    return {11'(bot), 11'(top), 11'(rx), 11'(lx)};
  endfunction

  task automatic set_player(input int t, input int b, input int l, input int r);
    topy = 11'(t); bottomy = 11'(b); leftx = 11'(l); rightx = 11'(r);
  endtask

  // Returns the cycle offset of done relative to the start cycle, or -1 on timeout.
  task automatic do_scan(output int lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (collide !== 1'b0) begin errors++; $display("FAIL reset_collide got %b want 0", collide); end
    checks++; if (hit_mask !== 4'b0) begin errors++; $display("FAIL reset_mask got %b want 0000", hit_mask); end
    checks++; if (hit_index !== 4'd0) begin errors++; $display("FAIL reset_index got %0d want 0", hit_index); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_resting_contact;
    int lat;
    set_player(100, 119, 50, 65);
    wall_list = {far_wall, far_wall, far_wall, w0};
    wall_en = 4'b0001;
    do_scan(lat);
    checks++; if (lat != (EE ? 3 : 6)) begin errors++; $display("FAIL rest_latency got %0d want %0d", lat, EE ? 3 : 6); end
    checks++; if (hit_mask !== 4'b0001) begin errors++; $display("FAIL rest_mask got %b want 0001", hit_mask); end
    checks++; if (collide !== 1'b1) begin errors++; $display("FAIL rest_collide got %b want 1", collide); end
    checks++; if (hit_index !== 4'd0) begin errors++; $display("FAIL rest_index got %0d want 0", hit_index); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rest_busy_at_done got %b want 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rest_done_pulse got %b want 0", done); end
    checks++; if (collide !== 1'b1) begin errors++; $display("FAIL rest_collide_held got %b want 1", collide); end
  endtask

  task automatic test_miss_enable;
    int lat;
    set_player(100, 119, 50, 65);
    wall_list = {far_wall, mkwall(130, 121, 80, 40), far_wall, far_wall};
    wall_en = 4'b1111;
    do_scan(lat);
    checks++; if (lat != 6) begin errors++; $display("FAIL miss_latency got %0d want 6", lat); end
    checks++; if (hit_mask !== 4'b0000) begin errors++; $display("FAIL miss_mask got %b want 0000", hit_mask); end
    checks++; if (collide !== 1'b0) begin errors++; $display("FAIL miss_collide got %b want 0", collide); end
    @(negedge clk);
    wall_list = {far_wall, mkwall(130, 121, 80, 40), w0, far_wall};
    wall_en = 4'b1101;
    do_scan(lat);
    checks++; if (hit_mask !== 4'b0000) begin errors++; $display("FAIL disabled_mask got %b want 0000", hit_mask); end
    checks++; if (collide !== 1'b0) begin errors++; $display("FAIL disabled_collide got %b want 0", collide); end
    @(negedge clk);
  endtask

  task automatic test_multi_hit;
    int lat;
    set_player(100, 119, 50, 65);
    wall_list = {w0, far_wall, w0, far_wall};
    wall_en = 4'b1111;
    do_scan(lat);
    checks++; if (lat != (EE ? 4 : 6)) begin errors++; $display("FAIL multi_latency got %0d want %0d", lat, EE ? 4 : 6); end
    checks++; if (hit_mask !== (EE ? 4'b0010 : 4'b1010)) begin errors++; $display("FAIL multi_mask got %b want %b", hit_mask, EE ? 4'b0010 : 4'b1010); end
    checks++; if (hit_index !== 4'd1) begin errors++; $display("FAIL multi_index got %0d want 1", hit_index); end
    checks++; if (collide !== 1'b1) begin errors++; $display("FAIL multi_collide got %b want 1", collide); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int ndone, first_at;
    logic [3:0] mask_at;
    set_player(100, 119, 50, 65);
    wall_list = {w0, far_wall, w0, far_wall};
    wall_en = 4'b1111;
    ndone = 0; first_at = -1; mask_at = 4'b0;
    start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = (c == 2);
      if (c == 3) topy = 11'd2000;
      if (done) begin
        ndone++;
        if (first_at < 0) begin first_at = c; mask_at = hit_mask; end
      end
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", ndone); end
    checks++; if (first_at != (EE ? 4 : 6)) begin errors++; $display("FAIL busy_start_latency got %0d want %0d", first_at, EE ? 4 : 6); end
    checks++; if (mask_at !== (EE ? 4'b0010 : 4'b1010)) begin errors++; $display("FAIL busy_start_mask got %b want %b", mask_at, EE ? 4'b0010 : 4'b1010); end
    topy = 11'd100;
  endtask

  task automatic test_reset_mid_scan;
    int lat, ndone;
    set_player(100, 119, 50, 65);
    wall_list = {far_wall, far_wall, far_wall, w0};
    wall_en = 4'b0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (hit_mask !== 4'b0) begin errors++; $display("FAIL midrst_mask got %b want 0000", hit_mask); end
    checks++; if (collide !== 1'b0) begin errors++; $display("FAIL midrst_collide got %b want 0", collide); end
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
    do_scan(lat);
    checks++; if (lat != (EE ? 3 : 6)) begin errors++; $display("FAIL postrst_latency got %0d want %0d", lat, EE ? 3 : 6); end
    checks++; if (hit_mask !== 4'b0001) begin errors++; $display("FAIL postrst_mask got %b want 0001", hit_mask); end
    @(negedge clk);
  endtask

  task automatic test_edge_overflow;
    int lat;
    set_player(2000, 2047, 10, 20);
    wall_list = {far_wall, far_wall, far_wall, mkwall(2047, 0, 2047, 0)};
    wall_en = 4'b0001;
    do_scan(lat);
    checks++; if (hit_mask !== 4'b0001) begin errors++; $display("FAIL ovf_mask got %b want 0001", hit_mask); end
    @(negedge clk);
    wall_list = {far_wall, far_wall, far_wall, mkwall(2047, 5, 2047, 0)};
    do_scan(lat);
    checks++; if (hit_mask !== 4'b0001) begin errors++; $display("FAIL ovf_nowrap_mask got %b want 0001", hit_mask); end
    @(negedge clk);
    set_player(2000, 2047, 10, 99);
    wall_list = {far_wall, far_wall, far_wall, mkwall(2047, 0, 2047, 100)};
    do_scan(lat);
    checks++; if (hit_mask !== 4'b0000) begin errors++; $display("FAIL ovf_edge_miss_mask got %b want 0000", hit_mask); end
    checks++; if (collide !== 1'b0) begin errors++; $display("FAIL ovf_edge_miss_collide got %b want 0", collide); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    topy = '0; bottomy = '0; leftx = '0; rightx = '0;
    wall_list = '0; wall_en = '0;
    far_wall = mkwall(1100, 1000, 1100, 1000);
    w0 = mkwall(127, 120, 80, 40);
    @(negedge clk);
    test_reset;
    test_resting_contact;
    test_miss_enable;
    test_multi_hit;
    test_back_to_back;
    test_reset_mid_scan;
    test_edge_overflow;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
